// File: rtl/mc_defs.sv
// Shared definitions for the multicycle MIPS main control: state encoding,
// opcodes, datapath select codes and the bundle of control outputs.
package mc_defs;

    localparam int OP_W = 6;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode: current state plus memory handshake to the
// datapath control bundle. Anything not set for a state stays 0.
module mc_ctrl_decode
    import mc_defs::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // Per-state control decode
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = ALUB_IMM_SH;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_ADDR, S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_REG;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_I_WB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUB_REG;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ILLEGAL: begin
                ctrl.illegal_op = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: state register, opcode-driven sequencing
// and reset gating of the decoded control outputs.
module mc_main_control
    import mc_defs::*;
#(
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            i_or_d,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            mem_to_reg,
    output logic            reg_dst,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_source,
    output logic            illegal_op
);

    state_t state_r;
    state_t next_s;
    ctrl_t  ctrl_s;
    ctrl_t  gated_s;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state sequencing; opcode only matters in DECODE and MEM_ADDR
    always_comb begin
        next_s = S_FETCH;
        case (state_r)
            S_FETCH:  next_s = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) begin
                    next_s = S_MEM_ADDR;
                end else if (opcode == OP_RTYPE) begin
                    next_s = S_R_EXEC;
                end else if (opcode == OP_BEQ) begin
                    next_s = S_BRANCH;
                end else if (opcode == OP_J) begin
                    next_s = S_JUMP;
                end else if (opcode == OP_ADDI) begin
                    next_s = S_I_EXEC;
                end else begin
                    next_s = S_ILLEGAL;
                end
            end
            // An opcode that changed to neither lw nor sw here never touches memory
            S_MEM_ADDR: begin
                if (opcode == OP_LW) begin
                    next_s = S_MEM_RD;
                end else if (opcode == OP_SW) begin
                    next_s = S_MEM_WR;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_MEM_RD: next_s = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR: next_s = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC: next_s = S_R_WB;
            S_I_EXEC: next_s = S_I_WB;
            default:  next_s = S_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state     (state_r),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_s)
    );

    // Reset forces every control low, dropping any strobe in the same cycle
    always_comb begin
        if (reset) begin
            gated_s = '0;
        end else begin
            gated_s = ctrl_s;
        end
    end

    assign pc_write      = gated_s.pc_write;
    assign pc_write_cond = gated_s.pc_write_cond;
    assign i_or_d        = gated_s.i_or_d;
    assign mem_read      = gated_s.mem_read;
    assign mem_write     = gated_s.mem_write;
    assign ir_write      = gated_s.ir_write;
    assign mem_to_reg    = gated_s.mem_to_reg;
    assign reg_dst       = gated_s.reg_dst;
    assign reg_write     = gated_s.reg_write;
    assign alu_src_a     = gated_s.alu_src_a;
    assign alu_src_b     = gated_s.alu_src_b;
    assign alu_op        = gated_s.alu_op;
    assign pc_source     = gated_s.pc_source;
    assign illegal_op    = gated_s.illegal_op;

endmodule

// File: tb/tb_mc_main_control.sv
// Self-checking bench for mc_main_control: an instruction-level model expands
// each instruction into its expected per-cycle control vectors.
module tb_mc_main_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mem_ready = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mc_main_control #(.OP_W(6)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op)
    );

    wire [16:0] obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                       pc_source, illegal_op};

    typedef struct {
        logic        mr;
        logic [5:0]  op;
        logic [16:0] exp;
        string       name;
    } step_t;

    step_t q[$];

    function automatic logic [16:0] cv(logic pcw, logic pcwc, logic iord, logic mr, logic mw,
                                       logic irw, logic m2r, logic rd, logic rw, logic asa,
                                       logic [1:0] asb, logic [1:0] aop, logic [1:0] pcs,
                                       logic ill);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ill};
    endfunction

    function automatic void add(logic mr, logic samp, logic [5:0] op, logic [16:0] e, string n);
        step_t s;
        s.mr   = mr;
        s.op   = samp ? op : 6'($urandom);
        s.exp  = e;
        s.name = n;
        q.push_back(s);
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Instruction-level model: fetch, decode, then the class-specific steps
    function automatic void model_instr(logic [5:0] op, int fw, int mw);
        for (int i = 0; i < fw; i++)
            add(1'b0, 1'b0, op, cv(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), "fetch_wait");
        add(1'b1, 1'b0, op, cv(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), "fetch");
        add(rbit(), 1'b1, op, cv(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), "decode");
        if (op == 6'b100011 || op == 6'b101011) begin
            add(rbit(), 1'b1, op, cv(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), "mem_addr");
            if (op == 6'b100011) begin
                for (int i = 0; i < mw; i++)
                    add(1'b0, 1'b0, op, cv(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), "mem_rd_wait");
                add(1'b1, 1'b0, op, cv(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), "mem_rd");
                add(rbit(), 1'b0, op, cv(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0), "mem_wb");
            end else begin
                for (int i = 0; i < mw; i++)
                    add(1'b0, 1'b0, op, cv(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), "mem_wr_wait");
                add(1'b1, 1'b0, op, cv(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), "mem_wr");
            end
        end else if (op == 6'b000000) begin
            add(rbit(), 1'b0, op, cv(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0), "r_exec");
            add(rbit(), 1'b0, op, cv(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0), "r_wb");
        end else if (op == 6'b001000) begin
            add(rbit(), 1'b0, op, cv(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), "i_exec");
            add(rbit(), 1'b0, op, cv(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0), "i_wb");
        end else if (op == 6'b000100) begin
            add(rbit(), 1'b0, op, cv(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0), "branch");
        end else if (op == 6'b000010) begin
            add(rbit(), 1'b0, op, cv(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0), "jump");
        end else begin
            add(rbit(), 1'b0, op, cv(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1), "illegal");
        end
    endfunction

    // Plays queued steps (all when cut < 0) and compares every cycle
    task automatic drive(input int cut);
        int n = 0;
        while (q.size() > 0 && (cut < 0 || n < cut)) begin
            step_t s = q.pop_front();
            @(negedge clk);
            mem_ready = s.mr;
            opcode    = s.op;
            #1;
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL %s: controls=%05h expected=%05h (t=%0t)", s.name, obs, s.exp, $time);
            end
            checks++;
            if ((mem_read & mem_write) !== 1'b0) begin
                errors++;
                $display("FAIL mem_rw_exclusive in %s: mem_read=%b mem_write=%b", s.name, mem_read, mem_write);
            end
            n++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset = 1'b1;
            mem_ready = 1'b1;
            #1;
            checks++;
            if (obs !== 17'd0) begin
                errors++;
                $display("FAIL reset_outputs: controls=%05h expected=00000", obs);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== cv(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0)) begin
            errors++;
            $display("FAIL reset_first_fetch: controls=%05h expected=%05h", obs,
                     cv(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0));
        end
        #1;
        mem_ready = 1'b0;
    endtask

    task automatic test_rtype();
        model_instr(6'b000000, 0, 0);
        drive(-1);
    endtask

    task automatic test_lw_wait();
        model_instr(6'b100011, 0, 2);
        drive(-1);
    endtask

    task automatic test_back_to_back();
        model_instr(6'b101011, 0, 0);
        model_instr(6'b000100, 0, 0);
        drive(-1);
    endtask

    task automatic test_illegal_and_jump();
        model_instr(6'b111111, 0, 0);
        model_instr(6'b000010, 1, 0);
        drive(-1);
    endtask

    task automatic test_reset_during_write();
        model_instr(6'b101011, 0, 3);
        drive(5);
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== 17'd0) begin
            errors++;
            $display("FAIL reset_drops_write: controls=%05h expected=00000", obs);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== cv(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0)) begin
            errors++;
            $display("FAIL fetch_after_reset: controls=%05h expected=%05h", obs,
                     cv(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0));
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        for (int k = 0; k < 40; k++) begin
            logic [5:0] op;
            int sel = $urandom_range(0, 6);
            if (sel < 6) begin
                op = ops[sel];
            end else begin
                do op = 6'($urandom);
                while (op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                       op == 6'b000100 || op == 6'b000010 || op == 6'b001000);
            end
            model_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
        end
        drive(-1);
        model_instr(6'b000000, 1, 0);
        drive(1);
        q.delete();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_back_to_back();
        test_illegal_and_jump();
        test_reset_during_write();
        test_rtype();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
